// File: rtl/pong_pkg.sv
// ---------------------------------------------------------------------------
// pong_pkg
// Shared definitions for the per-side player control path: command bit
// positions, owner and jump-FSM state encodings, and the default tick
// constants used as parameter defaults by player_ctrl_arbiter.
// ---------------------------------------------------------------------------
package pong_pkg;

    // Default tick constants (one tick = one video frame)
    localparam int unsigned DEF_DLY_MAX        = 15;
    localparam int unsigned DEF_DLY_EASY       = 12;
    localparam int unsigned DEF_DLY_MED        = 6;
    localparam int unsigned DEF_DLY_HARD       = 2;
    localparam int unsigned DEF_TAKEOVER_TICKS = 90;
    localparam int unsigned DEF_JUMP_COOL      = 30;
    localparam int unsigned DEF_SMASH_MAX      = 20;

    // Command word layout: {left, right, jump, smash}
    localparam int CMD_W = 4;
    localparam int CMD_L = 3;
    localparam int CMD_R = 2;
    localparam int CMD_J = 1;
    localparam int CMD_S = 0;

    typedef logic [CMD_W-1:0] cmd_t;

    typedef enum logic {
        OWN_HUMAN = 1'b0,
        OWN_CPU   = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        J_IDLE = 2'd0,
        J_FIRE = 2'd1,
        J_COOL = 2'd2
    } jump_e;

endpackage

// File: rtl/player_ctrl_arbiter_if.sv
// ---------------------------------------------------------------------------
// player_ctrl_arbiter_if
// Groups the frame tick, the two command sources and the player-engine
// outputs of one side.
//   master : source/sink side (drives tick, enables and commands)
//   slave  : the arbiter (drives move_left/right, jump, smash, owner_cpu)
// ---------------------------------------------------------------------------
interface player_ctrl_arbiter_if;

    logic       frame_tick;   // one-clk pulse per video frame
    logic       cpu_en;       // CPU may own this side
    logic [1:0] difficulty;   // 0 easy .. 3 instant
    logic [3:0] hum_cmd;      // human {left,right,jump,smash}
    logic [3:0] cpu_cmd;      // CPU {left,right,jump,smash}

    logic       move_left;
    logic       move_right;
    logic       jump;         // one-tick jump request
    logic       smash;
    logic       owner_cpu;    // 1 = CPU owns this side

    modport master (
        output frame_tick, cpu_en, difficulty, hum_cmd, cpu_cmd,
        input  move_left, move_right, jump, smash, owner_cpu
    );

    modport slave (
        input  frame_tick, cpu_en, difficulty, hum_cmd, cpu_cmd,
        output move_left, move_right, jump, smash, owner_cpu
    );

endinterface

// File: rtl/cmd_delay_line.sv
// ---------------------------------------------------------------------------
// cmd_delay_line
// DEPTH x WIDTH shift register advanced by tick_i, with a synchronous clear
// and a variable read tap. Tap 0 is the live input; tap k returns the value
// shifted in k ticks ago.
//   clk, rst_n : clock, asynchronous active-low reset
//   tick_i     : shift enable (also qualifies clr_i)
//   clr_i      : zero every stage instead of shifting
//   din_i      : value shifted in on each tick
//   tap_i      : read tap, 0..DEPTH
//   dout_o     : tapped value (combinational)
// ---------------------------------------------------------------------------
module cmd_delay_line #(
    parameter int DEPTH = 15,
    parameter int WIDTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         tick_i,
    input  logic                         clr_i,
    input  logic [WIDTH-1:0]             din_i,
    input  logic [$clog2(DEPTH+1)-1:0]   tap_i,
    output logic [WIDTH-1:0]             dout_o
);

    localparam int TAP_W = $clog2(DEPTH + 1);
    localparam logic [TAP_W-1:0] TAP_LIM = TAP_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its neighbour's old value; blocking here would collapse the
    // shift into a single copy.
    // NOTE: this storage is reset, not left uninitialised: the CPU command
    // path reads it directly, so stale contents would leak into the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (tick_i) begin
            if (clr_i) begin
                for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            end else begin
                mem_q[0] <= din_i;
                for (int i = 1; i < DEPTH; i++) mem_q[i] <= mem_q[i-1];
            end
        end
    end

    // NOTE: the output gets a default before any branch so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        dout_o = din_i;
        if (tap_i != '0 && tap_i <= TAP_LIM) dout_o = mem_q[tap_i - 1'b1];
    end

endmodule

// File: rtl/player_ctrl_arbiter.sv
// ---------------------------------------------------------------------------
// player_ctrl_arbiter
// Per-side command arbiter between a human keypad and the CPU player AI.
// Chooses the owner, delays CPU commands by a difficulty-dependent reaction
// time, resolves left/right conflicts, turns jump into a one-tick pulse with
// a cooldown and limits how long smash may be held. All state advances only
// in the clk where frame_tick is high; outputs are registered.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : player_ctrl_arbiter_if.slave (tick, cpu_en, difficulty,
//                hum_cmd, cpu_cmd in; move_left/right, jump, smash,
//                owner_cpu out)
// ---------------------------------------------------------------------------
module player_ctrl_arbiter
    import pong_pkg::*;
#(
    parameter int unsigned DLY_MAX        = DEF_DLY_MAX,
    parameter int unsigned DLY_EASY       = DEF_DLY_EASY,
    parameter int unsigned DLY_MED        = DEF_DLY_MED,
    parameter int unsigned DLY_HARD       = DEF_DLY_HARD,
    parameter int unsigned TAKEOVER_TICKS = DEF_TAKEOVER_TICKS,
    parameter int unsigned JUMP_COOL      = DEF_JUMP_COOL,
    parameter int unsigned SMASH_MAX      = DEF_SMASH_MAX
) (
    input  logic                 clk,
    input  logic                 rst_n,
    player_ctrl_arbiter_if.slave bus
);

    localparam int TAP_W  = $clog2(DLY_MAX + 1);
    localparam int IDLE_W = $clog2(TAKEOVER_TICKS + 1);
    localparam int JCNT_W = $clog2(JUMP_COOL + 1);
    localparam int SCNT_W = $clog2(SMASH_MAX + 1);

    localparam logic [IDLE_W-1:0] IDLE_LIM = IDLE_W'(TAKEOVER_TICKS);
    localparam logic [JCNT_W-1:0] JCNT_LIM = JCNT_W'(JUMP_COOL);
    localparam logic [SCNT_W-1:0] SCNT_LIM = SCNT_W'(SMASH_MAX);

    // State registers and next-state values
    owner_e            owner_q, owner_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    jump_e             jst_q, jst_d;
    logic [JCNT_W-1:0] jcnt_q, jcnt_d;
    logic              sel_jump_q;
    logic [SCNT_W-1:0] scnt_q, scnt_d;
    logic              mvl_q, mvl_d;
    logic              mvr_q, mvr_d;
    logic              smash_q, smash_d;

    // Command path
    logic [TAP_W-1:0]  tap;
    logic              dly_clr;
    logic              hum_active;
    cmd_t              tap_cmd;
    cmd_t              cpu_sel;
    cmd_t              sel;

    // Reaction delay per difficulty; difficulty 3 reads the live CPU command.
    always_comb begin
        tap = '0;
        case (bus.difficulty)
            2'd0:    tap = TAP_W'(DLY_EASY);
            2'd1:    tap = TAP_W'(DLY_MED);
            2'd2:    tap = TAP_W'(DLY_HARD);
            default: tap = '0;
        endcase
    end

    cmd_delay_line #(
        .DEPTH (DLY_MAX),
        .WIDTH (CMD_W)
    ) u_delay (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_i (bus.frame_tick),
        .clr_i  (dly_clr),
        .din_i  (bus.cpu_cmd),
        .tap_i  (tap),
        .dout_o (tap_cmd)
    );

    // Owner selection. idle_q counts idle ticks since the human last acted;
    // the CPU takes over on the first idle tick after TAKEOVER_TICKS of them
    // have elapsed. Human input (or losing cpu_en) restarts the count.
    always_comb begin
        hum_active = |bus.hum_cmd;
        owner_d    = owner_q;
        idle_d     = idle_q;
        dly_clr    = 1'b0;
        if (!bus.cpu_en) begin
            owner_d = OWN_HUMAN;
            idle_d  = '0;
        end else if (owner_q == OWN_HUMAN) begin
            if (hum_active) begin
                idle_d = '0;
            end else if (idle_q != IDLE_LIM) begin
                idle_d = idle_q + 1'b1;
            end else begin
                owner_d = OWN_CPU;
                dly_clr = 1'b1;
            end
        end else if (hum_active) begin
            owner_d = OWN_HUMAN;
            idle_d  = '0;
        end
    end

    // The selection follows the owner being entered on this tick. On the
    // takeover tick the line is being cleared, so any non-zero tap reads 0.
    always_comb begin
        cpu_sel = (dly_clr && tap != '0) ? '0 : tap_cmd;
        sel     = (owner_d == OWN_CPU) ? cpu_sel : bus.hum_cmd;
    end

    // Moves and smash limiter
    always_comb begin
        mvl_d   = sel[CMD_L] & ~sel[CMD_R];
        mvr_d   = sel[CMD_R] & ~sel[CMD_L];
        smash_d = 1'b0;
        scnt_d  = '0;
        if (sel[CMD_S]) begin
            smash_d = (scnt_q < SCNT_LIM);
            scnt_d  = (scnt_q == SCNT_LIM) ? scnt_q : scnt_q + 1'b1;
        end
    end

    // Jump FSM: fires only on a rising edge of the selected jump bit, and only
    // from J_IDLE, so a held request or one landing in cooldown never fires.
    always_comb begin
        jst_d  = jst_q;
        jcnt_d = jcnt_q;
        case (jst_q)
            J_IDLE: begin
                if (sel[CMD_J] && !sel_jump_q) jst_d = J_FIRE;
            end
            J_FIRE: begin
                jst_d  = J_COOL;
                jcnt_d = JCNT_LIM;
            end
            J_COOL: begin
                if (jcnt_q == '0) jst_d  = J_IDLE;
                else              jcnt_d = jcnt_q - 1'b1;
            end
            default: jst_d = J_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q    <= OWN_HUMAN;
            idle_q     <= '0;
            jst_q      <= J_IDLE;
            jcnt_q     <= '0;
            sel_jump_q <= 1'b0;
            scnt_q     <= '0;
            mvl_q      <= 1'b0;
            mvr_q      <= 1'b0;
            smash_q    <= 1'b0;
        end else if (bus.frame_tick) begin
            owner_q    <= owner_d;
            idle_q     <= idle_d;
            jst_q      <= jst_d;
            jcnt_q     <= jcnt_d;
            sel_jump_q <= sel[CMD_J];
            scnt_q     <= scnt_d;
            mvl_q      <= mvl_d;
            mvr_q      <= mvr_d;
            smash_q    <= smash_d;
        end
    end

    assign bus.move_left  = mvl_q;
    assign bus.move_right = mvr_q;
    assign bus.jump       = (jst_q == J_FIRE);
    assign bus.smash      = smash_q;
    assign bus.owner_cpu  = (owner_q == OWN_CPU);

endmodule

// File: tb/tb_player_ctrl_arbiter.sv
// ---------------------------------------------------------------------------
// tb_player_ctrl_arbiter
// Self-checking bench for player_ctrl_arbiter. A behavioural model tracks a
// history of CPU commands, a count of quiet ticks, the tick of the last jump
// pulse and the current smash run length, and predicts all five outputs
// after every frame tick.
// ---------------------------------------------------------------------------
module tb_player_ctrl_arbiter;

    localparam int TAKEOVER   = 90;
    localparam int JUMP_COOL  = 30;
    localparam int SMASH_MAX  = 20;
    localparam int HIST_DEPTH = 15;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests  = 0;
    int   n_failed = 0;

    player_ctrl_arbiter_if bus ();

    player_ctrl_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [3:0] hist [$];    // hist[0] = CPU command of the previous tick
    bit         m_cpu;       // CPU owns the side
    int         quiet;       // consecutive quiet ticks while human owns with cpu_en
    int         last_fire;   // tick index of the last jump pulse
    bit         prev_j;      // selected jump bit of the previous tick
    int         run;         // consecutive ticks with selected smash high
    int         t_now;       // tick index
    logic [4:0] exp_vec;     // {move_left, move_right, jump, smash, owner_cpu}

    function automatic logic [4:0] obs();
        return {bus.move_left, bus.move_right, bus.jump, bus.smash, bus.owner_cpu};
    endfunction

    function automatic int tap_of(input logic [1:0] d);
        case (d)
            2'd0:    return 12;
            2'd1:    return 6;
            2'd2:    return 2;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < HIST_DEPTH; i++) hist.push_back(4'b0);
        m_cpu     = 1'b0;
        quiet     = 0;
        last_fire = -1000;
        prev_j    = 1'b0;
        run       = 0;
        t_now     = 0;
        exp_vec   = '0;
    endtask

    task automatic model_step(input logic [3:0] hum, input logic [3:0] cpu,
                              input bit en, input logic [1:0] diff);
        int         tap;
        bit         takeover;
        bit         fire;
        logic [3:0] dly;
        logic [3:0] sel;
        t_now++;
        tap      = tap_of(diff);
        takeover = 1'b0;
        if (!en || hum != 4'b0) begin
            m_cpu = 1'b0;
            quiet = 0;
        end else if (!m_cpu) begin
            quiet++;
            if (quiet > TAKEOVER) begin
                m_cpu    = 1'b1;
                takeover = 1'b1;
            end
        end
        if (takeover) for (int i = 0; i < HIST_DEPTH; i++) hist[i] = 4'b0;
        dly = (tap == 0) ? cpu : hist[tap-1];
        if (!takeover) begin
            hist.push_front(cpu);
            void'(hist.pop_back());
        end
        sel = m_cpu ? dly : hum;
        // A pulse on tick t blocks new pulses until: pulse tick, entry into
        // cooldown, JUMP_COOL countdown ticks, return to idle.
        fire = sel[1] && !prev_j && (t_now - last_fire >= JUMP_COOL + 3);
        if (fire) last_fire = t_now;
        prev_j = sel[1];
        run = sel[0] ? run + 1 : 0;
        exp_vec = {sel[3] && !sel[2], sel[2] && !sel[3], fire,
                   sel[0] && (run <= SMASH_MAX), m_cpu};
    endtask

    // Drive one frame tick and advance the model; outputs are sampled by the
    // caller on the falling edge after the sampling edge.
    task automatic drive_tick(input logic [3:0] hum, input logic [3:0] cpu,
                              input bit en, input logic [1:0] diff);
        @(negedge clk);
        bus.hum_cmd    = hum;
        bus.cpu_cmd    = cpu;
        bus.cpu_en     = en;
        bus.difficulty = diff;
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        model_step(hum, cpu, en, diff);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (obs() !== 5'b0) begin
            n_failed++;
            $display("FAIL reset_outputs: got %b expected %b", obs(), 5'b0);
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_takeover();
        for (int i = 1; i <= TAKEOVER + 1; i++) begin
            drive_tick(4'b0, 4'($urandom), 1'b1, 2'd1);
            n_tests++;
            if (obs() !== exp_vec) begin
                n_failed++;
                $display("FAIL takeover tick %0d: got %b expected %b", i, obs(), exp_vec);
            end
            if (i == TAKEOVER) begin
                n_tests++;
                if (bus.owner_cpu !== 1'b0) begin
                    n_failed++;
                    $display("FAIL takeover_early: owner_cpu=%b expected 0", bus.owner_cpu);
                end
            end
        end
        n_tests++;
        if (bus.owner_cpu !== 1'b1) begin
            n_failed++;
            $display("FAIL takeover_91: owner_cpu=%b expected 1", bus.owner_cpu);
        end
    endtask

    task automatic test_cpu_delay();
        logic want;
        for (int i = 0; i < 8; i++) drive_tick(4'b0, 4'b0, 1'b1, 2'd1);
        drive_tick(4'b0, 4'b1000, 1'b1, 2'd1);
        for (int k = 1; k <= 8; k++) begin
            drive_tick(4'b0, 4'b0, 1'b1, 2'd1);
            want = (k == 6);
            n_tests++;
            if (bus.move_left !== want || obs() !== exp_vec) begin
                n_failed++;
                $display("FAIL cpu_delay_med N+%0d: got %b expected %b", k, obs(), exp_vec);
            end
        end
        drive_tick(4'b0, 4'b1000, 1'b1, 2'd3);
        n_tests++;
        if (bus.move_left !== 1'b1) begin
            n_failed++;
            $display("FAIL cpu_delay_instant: move_left=%b expected 1", bus.move_left);
        end
        drive_tick(4'b0, 4'b0, 1'b1, 2'd3);
        n_tests++;
        if (bus.move_left !== 1'b0) begin
            n_failed++;
            $display("FAIL cpu_delay_instant_off: move_left=%b expected 0", bus.move_left);
        end
    endtask

    task automatic test_human_override();
        for (int i = 0; i < 10; i++) drive_tick(4'b0, 4'b1000, 1'b1, 2'd1);
        drive_tick(4'b0100, 4'b1000, 1'b1, 2'd1);
        n_tests++;
        if (bus.owner_cpu !== 1'b0 || bus.move_right !== 1'b1 || bus.move_left !== 1'b0) begin
            n_failed++;
            $display("FAIL override_tick: got %b expected owner 0, move_right 1", obs());
        end
        for (int i = 1; i <= TAKEOVER + 1; i++) begin
            drive_tick(4'b0, 4'b1000, 1'b1, 2'd1);
            n_tests++;
            if (obs() !== exp_vec) begin
                n_failed++;
                $display("FAIL override_idle tick %0d: got %b expected %b", i, obs(), exp_vec);
            end
        end
        n_tests++;
        if (bus.owner_cpu !== 1'b1 || bus.move_left !== 1'b0) begin
            n_failed++;
            $display("FAIL override_return: got %b expected owner 1 with cleared line", obs());
        end
        for (int i = 1; i <= 8; i++) begin
            drive_tick(4'b0, 4'b1000, 1'b1, 2'd1);
            n_tests++;
            if (obs() !== exp_vec) begin
                n_failed++;
                $display("FAIL override_refill tick %0d: got %b expected %b", i, obs(), exp_vec);
            end
        end
    endtask

    task automatic test_jump();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            drive_tick(4'b0010, 4'($urandom), 1'b0, 2'($urandom));
            pulses += int'(bus.jump);
            n_tests++;
            if (obs() !== exp_vec) begin
                n_failed++;
                $display("FAIL jump_hold tick %0d: got %b expected %b", i, obs(), exp_vec);
            end
        end
        n_tests++;
        if (pulses !== 1) begin
            n_failed++;
            $display("FAIL jump_hold_count: got %0d pulses expected 1", pulses);
        end
        drive_tick(4'b0, 4'b0, 1'b0, 2'd0);
        pulses = 0;
        drive_tick(4'b0010, 4'b0, 1'b0, 2'd0);
        pulses += int'(bus.jump);
        for (int i = 0; i < 10; i++) drive_tick(4'b0, 4'b0, 1'b0, 2'd0);
        for (int i = 0; i < 30; i++) begin
            drive_tick(4'b0010, 4'b0, 1'b0, 2'd0);
            pulses += int'(bus.jump);
        end
        n_tests++;
        if (pulses !== 1) begin
            n_failed++;
            $display("FAIL jump_cooldown: got %0d pulses expected 1", pulses);
        end
        drive_tick(4'b0, 4'b0, 1'b0, 2'd0);
        drive_tick(4'b0010, 4'b0, 1'b0, 2'd0);
        n_tests++;
        if (bus.jump !== 1'b1 || obs() !== exp_vec) begin
            n_failed++;
            $display("FAIL jump_refire: got %b expected %b", obs(), exp_vec);
        end
    endtask

    task automatic test_smash();
        int   highs;
        logic last;
        highs = 0;
        last  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            drive_tick(4'b0001, 4'($urandom), 1'b0, 2'd0);
            highs += int'(bus.smash);
            last   = bus.smash;
            n_tests++;
            if (obs() !== exp_vec) begin
                n_failed++;
                $display("FAIL smash_hold tick %0d: got %b expected %b", i, obs(), exp_vec);
            end
        end
        n_tests++;
        if (highs !== SMASH_MAX || last !== 1'b0) begin
            n_failed++;
            $display("FAIL smash_limit: got %0d high ticks (last %b) expected %0d (last 0)",
                     highs, last, SMASH_MAX);
        end
        drive_tick(4'b0, 4'b0, 1'b0, 2'd0);
        drive_tick(4'b0001, 4'b0, 1'b0, 2'd0);
        n_tests++;
        if (bus.smash !== 1'b1) begin
            n_failed++;
            $display("FAIL smash_repress: smash=%b expected 1", bus.smash);
        end
    endtask

    task automatic test_conflict_async_reset();
        drive_tick(4'b1100, 4'b0, 1'b0, 2'd0);
        n_tests++;
        if (bus.move_left !== 1'b0 || bus.move_right !== 1'b0) begin
            n_failed++;
            $display("FAIL conflict: got %b expected both moves 0", obs());
        end
        for (int i = 0; i < 5; i++) begin
            drive_tick(4'b1011, 4'b0, 1'b0, 2'd0);
            n_tests++;
            if (obs() !== exp_vec) begin
                n_failed++;
                $display("FAIL pre_reset tick %0d: got %b expected %b", i, obs(), exp_vec);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (obs() !== 5'b0) begin
            n_failed++;
            $display("FAIL async_reset: got %b expected %b", obs(), 5'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        drive_tick(4'b1011, 4'b0, 1'b0, 2'd0);
        n_tests++;
        if (bus.jump !== 1'b1 || obs() !== exp_vec) begin
            n_failed++;
            $display("FAIL after_reset_tick: got %b expected %b", obs(), exp_vec);
        end
    endtask

    task automatic test_random();
        bit         en;
        logic [1:0] diff;
        logic [3:0] hum;
        int         gap;
        en   = 1'b1;
        diff = 2'd2;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) en = !en;
            if ($urandom_range(0, 49) == 0) diff = 2'($urandom_range(0, 3));
            hum = ($urandom_range(0, 99) == 0) ? 4'($urandom) : 4'b0;
            drive_tick(hum, 4'($urandom), en, diff);
            n_tests++;
            if (obs() !== exp_vec) begin
                n_failed++;
                $display("FAIL random tick %0d: got %b expected %b", i, obs(), exp_vec);
            end
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                bus.hum_cmd    = 4'($urandom);
                bus.cpu_cmd    = 4'($urandom);
                bus.cpu_en     = 1'($urandom);
                bus.difficulty = 2'($urandom);
                n_tests++;
                if (obs() !== exp_vec) begin
                    n_failed++;
                    $display("FAIL random_hold tick %0d: got %b expected %b", i, obs(), exp_vec);
                end
            end
        end
    endtask

    initial begin
        bus.frame_tick = 1'b0;
        bus.cpu_en     = 1'b0;
        bus.difficulty = 2'd0;
        bus.hum_cmd    = 4'b0;
        bus.cpu_cmd    = 4'b0;
        test_reset();
        test_takeover();
        test_cpu_delay();
        test_human_override();
        test_jump();
        test_smash();
        test_conflict_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
